trng_status_ctrl: RTL and testbench

Parametrised board-level housekeeping block for TRNG top levels. It generates the core reset from PLL lock and a hold counter, with lock-loss re-entry. It also drives a status LED bank by periodically sampling one of N_CH packed status channels, selected manually or by auto-rotation. It sits between the board pins/PLL and trng_top, replacing ad-hoc reset counters and LED sampling in each board top.

---
 rtl/trng_status_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_trng_status_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_status_ctrl.sv
// trng_status_ctrl: board housekeeping for TRNG top levels.
//   - Core reset generation from PLL lock with a hold counter and
//     filtered lock-loss re-entry (HOLD -> RUN <-> LOSS -> HOLD).
//   - Status LED bank fed by periodic sampling of one of N_CH packed
//     status channels, selected manually or by auto-rotation.
// Optional feature macro: STATUS_HEARTBEAT_EN adds o_heartbeat, which
// toggles on every sample tick while the core is out of reset.
module trng_status_ctrl #(
    parameter int RST_CYCLES   = 134217728,
    parameter int LOCK_FILT    = 8,
    parameter int SAMPLE_SHIFT = 23,
    parameter int N_CH         = 4,
    parameter int DAT_W        = 4,
    parameter int LED_W        = 4,
    parameter int ROT_TICKS    = 8,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_pll_lock,
    input  logic [N_CH*DAT_W-1:0]   i_dat,
    input  logic                    i_auto,
    input  logic [CH_W-1:0]         i_ch_sel,
    output logic                    o_core_reset,
    output logic [LED_W-1:0]        o_led,
    output logic [CH_W-1:0]         o_ch
`ifdef STATUS_HEARTBEAT_EN
    ,
    output logic                    o_heartbeat
`endif
);

    // Counter widths: each counter only ever stores values up to LIMIT-1,
    // the terminal value is detected before the increment.
    localparam int HOLD_W = $clog2(RST_CYCLES);
    localparam int LOSS_W = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
    localparam int ROT_W  = (ROT_TICKS > 1) ? $clog2(ROT_TICKS) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOCK_FILT - 1);
    localparam logic [ROT_W-1:0]  ROT_LAST  = ROT_W'(ROT_TICKS - 1);
    localparam logic [CH_W-1:0]   CH_MAX    = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        LOSS = 2'd2
    } state_t;

    state_t                  state_r, state_n_s;
    logic [HOLD_W-1:0]       hold_cnt_r, hold_cnt_n_s;
    logic [LOSS_W-1:0]       loss_cnt_r, loss_cnt_n_s;
    logic                    core_reset_r;
    logic [SAMPLE_SHIFT-1:0] tick_cnt_r;
    logic                    tick_s;
    logic [ROT_W-1:0]        rot_cnt_r, rot_cnt_n_s;
    logic [CH_W-1:0]         nch_s;
    logic [CH_W-1:0]         ch_r;
    logic [LED_W-1:0]        led_r;
    logic [DAT_W-1:0]        ch_dat_s;
    logic [LED_W-1:0]        led_n_s;
    int                      ch_base_s;

    assign o_core_reset = core_reset_r;
    assign o_led        = led_r;
    assign o_ch         = ch_r;

    // Sample tick only exists while the core is out of reset.
    assign tick_s = ~core_reset_r & (&tick_cnt_r);

    // Reset FSM next-state: hold counting, lock-loss filtering.
    always_comb begin
        state_n_s    = state_r;
        hold_cnt_n_s = hold_cnt_r;
        loss_cnt_n_s = loss_cnt_r;
        case (state_r)
            HOLD: begin
                if (i_pll_lock) begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_n_s    = RUN;
                        hold_cnt_n_s = '0;
                    end else begin
                        hold_cnt_n_s = hold_cnt_r + HOLD_W'(1);
                    end
                end else begin
                    hold_cnt_n_s = '0;
                end
            end
            RUN: begin
                if (!i_pll_lock) begin
                    if (LOCK_FILT == 1) begin
                        state_n_s    = HOLD;
                        hold_cnt_n_s = '0;
                    end else begin
                        state_n_s    = LOSS;
                        loss_cnt_n_s = LOSS_W'(1);
                    end
                end else begin
                    loss_cnt_n_s = '0;
                end
            end
            LOSS: begin
                if (i_pll_lock) begin
                    state_n_s    = RUN;
                    loss_cnt_n_s = '0;
                end else if (loss_cnt_r == LOSS_LAST) begin
                    state_n_s    = HOLD;
                    loss_cnt_n_s = '0;
                    hold_cnt_n_s = '0;
                end else begin
                    loss_cnt_n_s = loss_cnt_r + LOSS_W'(1);
                end
            end
            default: begin
                state_n_s    = HOLD;
                hold_cnt_n_s = '0;
                loss_cnt_n_s = '0;
            end
        endcase
    end

    // Reset FSM state, counters and the registered core reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r      <= HOLD;
            hold_cnt_r   <= '0;
            loss_cnt_r   <= '0;
            core_reset_r <= 1'b1;
        end else begin
            state_r      <= state_n_s;
            hold_cnt_r   <= hold_cnt_n_s;
            loss_cnt_r   <= loss_cnt_n_s;
            core_reset_r <= (state_n_s == HOLD);
        end
    end

    // Sample tick counter: runs out of reset, restarts on every HOLD entry.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tick_cnt_r <= '0;
        end else if (state_n_s == HOLD) begin
            tick_cnt_r <= '0;
        end else if (!core_reset_r) begin
            tick_cnt_r <= tick_cnt_r + SAMPLE_SHIFT'(1);
        end else begin
            tick_cnt_r <= tick_cnt_r;
        end
    end

    // Channel choice for the next tick: clamped manual select or rotation.
    always_comb begin
        nch_s       = ch_r;
        rot_cnt_n_s = rot_cnt_r;
        if (i_auto) begin
            if (rot_cnt_r == ROT_LAST) begin
                rot_cnt_n_s = '0;
                if (ch_r == CH_MAX) begin
                    nch_s = '0;
                end else begin
                    nch_s = ch_r + CH_W'(1);
                end
            end else begin
                rot_cnt_n_s = rot_cnt_r + ROT_W'(1);
            end
        end else begin
            rot_cnt_n_s = '0;
            if (i_ch_sel > CH_MAX) begin
                nch_s = CH_MAX;
            end else begin
                nch_s = i_ch_sel;
            end
        end
    end

    assign ch_base_s = int'(nch_s) * DAT_W;
    assign ch_dat_s  = i_dat[ch_base_s +: DAT_W];

    generate
        if (DAT_W >= LED_W) begin : g_led_trunc
            assign led_n_s = ch_dat_s[LED_W-1:0];
        end else begin : g_led_zext
            assign led_n_s = {{(LED_W - DAT_W){1'b0}}, ch_dat_s};
        end
    endgenerate

    // Display registers: channel index and LED value change together on ticks.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rot_cnt_r <= '0;
            ch_r      <= '0;
            led_r     <= '0;
        end else if (tick_s) begin
            rot_cnt_r <= rot_cnt_n_s;
            ch_r      <= nch_s;
            led_r     <= led_n_s;
        end else begin
            rot_cnt_r <= rot_cnt_r;
            ch_r      <= ch_r;
            led_r     <= led_r;
        end
    end

`ifdef STATUS_HEARTBEAT_EN
    logic heartbeat_r;
    assign o_heartbeat = heartbeat_r;

    // Heartbeat: toggles per tick while running, held low in HOLD.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            heartbeat_r <= 1'b0;
        end else if (state_n_s == HOLD) begin
            heartbeat_r <= 1'b0;
        end else if (tick_s) begin
            heartbeat_r <= ~heartbeat_r;
        end else begin
            heartbeat_r <= heartbeat_r;
        end
    end
`endif

endmodule

// File: tb/tb_trng_status_ctrl.sv
// Self-checking bench for trng_status_ctrl: directed scenarios with
// fixed expected values, then randomized traffic against a cycle model
// expressed as lock streaks, tick phase and rotation counts.
module tb_trng_status_ctrl;

    localparam int RST_CYCLES   = 16;
    localparam int LOCK_FILT    = 4;
    localparam int SAMPLE_SHIFT = 4;
    localparam int N_CH         = 3;
    localparam int DAT_W        = 4;
    localparam int LED_W        = 4;
    localparam int ROT_TICKS    = 2;
    localparam int CH_W         = 2;
    localparam int TICK_P       = 1 << SAMPLE_SHIFT;

    logic                  i_clk;
    logic                  i_reset;
    logic                  i_pll_lock;
    logic [N_CH*DAT_W-1:0] i_dat;
    logic                  i_auto;
    logic [CH_W-1:0]       i_ch_sel;
    logic                  o_core_reset;
    logic [LED_W-1:0]      o_led;
    logic [CH_W-1:0]       o_ch;
`ifdef STATUS_HEARTBEAT_EN
    logic                  o_heartbeat;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    bit m_rst;
    int m_streak;
    int m_low;
    int m_phase;
    int m_rot;
    int m_ch;
    int m_led;
    bit m_hb;

    trng_status_ctrl #(
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_FILT   (LOCK_FILT),
        .SAMPLE_SHIFT(SAMPLE_SHIFT),
        .N_CH        (N_CH),
        .DAT_W       (DAT_W),
        .LED_W       (LED_W),
        .ROT_TICKS   (ROT_TICKS)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_pll_lock  (i_pll_lock),
        .i_dat       (i_dat),
        .i_auto      (i_auto),
        .i_ch_sel    (i_ch_sel),
        .o_core_reset(o_core_reset),
        .o_led       (o_led),
        .o_ch        (o_ch)
`ifdef STATUS_HEARTBEAT_EN
        ,
        .o_heartbeat (o_heartbeat)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_init();
        m_rst    = 1'b1;
        m_streak = 0;
        m_low    = 0;
        m_phase  = 0;
        m_rot    = 0;
        m_ch     = 0;
        m_led    = 0;
        m_hb     = 1'b0;
    endtask

    // One clock edge of the reference behaviour, using the current inputs.
    task automatic model_update();
        bit tick;
        int nch;
        tick = !m_rst && ((m_phase % TICK_P) == TICK_P - 1);
        if (tick) begin
            if (!i_auto) begin
                m_rot = 0;
                nch = (int'(i_ch_sel) > N_CH - 1) ? N_CH - 1 : int'(i_ch_sel);
            end else begin
                m_rot++;
                if (m_rot == ROT_TICKS) begin
                    m_rot = 0;
                    nch = (m_ch + 1) % N_CH;
                end else begin
                    nch = m_ch;
                end
            end
            m_ch  = nch;
            m_led = int'(i_dat >> (nch * DAT_W)) & ((1 << LED_W) - 1);
            m_hb  = !m_hb;
        end
        if (m_rst) begin
            if (i_pll_lock) begin
                m_streak++;
                if (m_streak == RST_CYCLES) begin
                    m_rst    = 1'b0;
                    m_streak = 0;
                    m_phase  = 0;
                    m_low    = 0;
                end
            end else begin
                m_streak = 0;
            end
        end else begin
            m_phase++;
            if (i_pll_lock) begin
                m_low = 0;
            end else begin
                m_low++;
                if (m_low == LOCK_FILT) begin
                    m_rst    = 1'b1;
                    m_low    = 0;
                    m_streak = 0;
                    m_phase  = 0;
                    m_hb     = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("core_reset", o_core_reset, m_rst);
        check("led", o_led, m_led);
        check("ch", o_ch, m_ch);
`ifdef STATUS_HEARTBEAT_EN
        check("heartbeat", o_heartbeat, m_hb);
`endif
    endtask

    task automatic step();
        @(posedge i_clk);
        model_update();
        #1;
        compare_all();
    endtask

    // Async reset: asserted between edges, held for 3 edges, released after an edge.
    task automatic do_reset();
        i_reset = 1'b1;
        model_init();
        #1;
        check("rst_core_reset", o_core_reset, 1);
        check("rst_led", o_led, 0);
        check("rst_ch", o_ch, 0);
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
    endtask

    // Count cycles until o_core_reset falls, bounded.
    task automatic count_release(input string tag, input int exp);
        int n;
        n = 0;
        while (o_core_reset && n < 100) begin
            step();
            n++;
        end
        check(tag, n, exp);
    endtask

    int auto_exp [6] = '{0, 1, 1, 2, 2, 0};
    int lowburst;

    initial begin
        i_reset    = 1'b0;
        i_pll_lock = 1'b0;
        i_dat      = 12'hCBA;
        i_auto     = 1'b0;
        i_ch_sel   = 2'd0;
        model_init();
        #2;

        // Reset release with lock held high
        do_reset();
        i_pll_lock = 1'b1;
        count_release("release_cycles", 16);
        check("release_ch", o_ch, 0);
        check("release_led", o_led, 0);

        // Lock bounce in HOLD restarts the hold count
        do_reset();
        repeat (10) step();
        i_pll_lock = 1'b0;
        step();
        i_pll_lock = 1'b1;
        count_release("bounce_release", 16);

        // Lock-loss filter: 3 low cycles tolerated, 4 forces re-reset
        repeat (2) step();
        i_pll_lock = 1'b0;
        repeat (3) step();
        check("loss3_core_reset", o_core_reset, 0);
        i_pll_lock = 1'b1;
        repeat (2) step();
        i_pll_lock = 1'b0;
        repeat (3) step();
        check("loss_pre4", o_core_reset, 0);
        step();
        check("loss4_core_reset", o_core_reset, 1);
        i_pll_lock = 1'b1;
        count_release("rerelease_cycles", 16);

        // Manual select, including clamping of an out-of-range index
        do_reset();
        i_auto   = 1'b0;
        i_ch_sel = 2'd1;
        i_dat    = 12'hCBA;
        count_release("man_release", 16);
        repeat (15) step();
        check("man_pretick_ch", o_ch, 0);
        step();
        check("man_ch1", o_ch, 1);
        check("man_led_b", o_led, 4'hB);
        i_ch_sel = 2'd3;
        repeat (16) step();
        check("man_ch_clamp", o_ch, 2);
        check("man_led_c", o_led, 4'hC);

        // Async reset mid-RUN clears outputs immediately
        do_reset();

        // Auto rotation sequence
        i_auto = 1'b1;
        count_release("auto_release", 16);
        for (int k = 0; k < 6; k++) begin
            repeat (16) step();
            check("auto_ch_seq", o_ch, auto_exp[k]);
            check("auto_led_seq", o_led, (32'hCBA >> (auto_exp[k] * 4)) & 32'hF);
        end

        // Randomized traffic against the model
        do_reset();
        lowburst = 0;
        for (int c = 0; c < 4000; c++) begin
            if (lowburst == 0 && $urandom_range(0, 99) == 0)
                lowburst = $urandom_range(1, 6);
            if (lowburst > 0) begin
                i_pll_lock = 1'b0;
                lowburst--;
            end else begin
                i_pll_lock = 1'b1;
            end
            if ($urandom_range(0, 59) == 0) i_auto = ~i_auto;
            if ($urandom_range(0, 19) == 0) i_ch_sel = CH_W'($urandom_range(0, 3));
            i_dat = 12'($urandom);
            if ($urandom_range(0, 1499) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
